// File: rtl/mcu_dispatch_if.sv
// mcu_dispatch_if
// Bundles the MCU byte link, the per-target forwarding bus and the interrupt
// lines of the MCU dispatcher.
//   data_in_strobe/data_in_start/data_in : byte link from the MCU
//   data_out                             : byte returned to the MCU
//   tgt_strobe/tgt_start/tgt_data        : forwarded bytes, one strobe per target
//   tgt_dout                             : target return buses, target i on [8i+7:8i]
//   tgt_int/int_out_n                    : target interrupt levels, merged MCU interrupt
// Modports: master = MCU plus targets (the environment), slave = dispatcher.
interface mcu_dispatch_if #(
  parameter int NUM_TGT = 4
);
  logic                   data_in_strobe;
  logic                   data_in_start;
  logic [7:0]             data_in;
  logic [7:0]             data_out;
  logic [NUM_TGT-1:0]     tgt_strobe;
  logic [NUM_TGT-1:0]     tgt_start;
  logic [7:0]             tgt_data;
  logic [8*NUM_TGT-1:0]   tgt_dout;
  logic [NUM_TGT-1:0]     tgt_int;
  logic                   int_out_n;

  modport master (
    output data_in_strobe, data_in_start, data_in, tgt_dout, tgt_int,
    input  data_out, tgt_strobe, tgt_start, tgt_data, int_out_n
  );

  modport slave (
    input  data_in_strobe, data_in_start, data_in, tgt_dout, tgt_int,
    output data_out, tgt_strobe, tgt_start, tgt_data, int_out_n
  );
endinterface

// File: rtl/mcu_dispatch.sv
// mcu_dispatch
// Routes framed bytes from the MCU link to one of NUM_TGT targets, or handles
// them locally (interrupt mask / status access). The first byte of a frame is
// the target id; the following bytes are forwarded one clk later.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : mcu_dispatch_if.slave (MCU link, target bus, interrupts)
// Parameters:
//   TIMEOUT : idle clk cycles inside an open frame before it is aborted
//   NUM_TGT : number of downstream targets (4 in this revision)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no frame open; non-start bytes ignored
// FWD_FIRST | target frame open, next byte is the target command byte
// FWD       | target frame open, bytes forwarded as plain data
// SELF      | frame addressed to the dispatcher itself
// DISCARD   | frame to an unknown id; bytes dropped, 0xFF returned
module mcu_dispatch #(
  parameter int TIMEOUT = 50000,
  parameter int NUM_TGT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mcu_dispatch_if.slave bus
);

  localparam int SW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] ID_SELF      = 8'h00;
  localparam logic [7:0] SUB_STATUS   = 8'h00;
  localparam logic [7:0] SUB_SET_MASK = 8'h01;
  localparam logic [7:0] SELF_ACK     = 8'h5D;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FWD_FIRST = 3'd1,
    FWD       = 3'd2,
    SELF      = 3'd3,
    DISCARD   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [SW-1:0]        sel_q, sel_nxt;
  logic [CW-1:0]        idle_cnt, idle_cnt_nxt;
  logic [3:0]           byte_cnt, byte_cnt_nxt;
  logic [3:0]           byte_idx;
  logic [7:0]           subcmd_q, subcmd_nxt;
  logic [NUM_TGT-1:0]   int_mask, int_mask_nxt;
  logic [7:0]           data_out_q, data_out_nxt;
  logic [NUM_TGT-1:0]   tgt_strobe_q, tgt_strobe_nxt;
  logic [NUM_TGT-1:0]   tgt_start_q, tgt_start_nxt;
  logic [7:0]           tgt_data_q, tgt_data_nxt;
  logic                 int_out_n_q;
  logic [7:0]           self_resp;
  logic [7:0]           sel_dout;
  logic [NUM_TGT-1:0]   sel_onehot;
  logic [NUM_TGT-1:0]   int_pend;

  logic start_byte;
  logic body_byte;
  logic id_is_tgt;
  logic timeout;

  assign start_byte = bus.data_in_strobe &  bus.data_in_start;
  assign body_byte  = bus.data_in_strobe & ~bus.data_in_start;
  assign id_is_tgt  = (bus.data_in != 8'h00) && (bus.data_in <= 8'(NUM_TGT));

  // A strobe in the terminal-count cycle wins over the timeout.
  assign timeout = (state != IDLE) && !bus.data_in_strobe &&
                   (idle_cnt == CW'(TIMEOUT));

  // Index of the byte being received now within a SELF frame (id is byte 0).
  assign byte_idx = (byte_cnt == 4'hF) ? 4'hF : byte_cnt + 4'd1;

  assign sel_nxt    = (start_byte && id_is_tgt) ? SW'(bus.data_in - 8'd1) : sel_q;
  assign sel_dout   = bus.tgt_dout[{sel_nxt, 3'b000} +: 8];
  assign sel_onehot = NUM_TGT'(1) << sel_q;
  assign int_pend   = bus.tgt_int & int_mask;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (start_byte) begin
      if (bus.data_in == ID_SELF) state_nxt = SELF;
      else if (id_is_tgt)         state_nxt = FWD_FIRST;
      else                        state_nxt = DISCARD;
    end else if (body_byte) begin
      if (state == FWD_FIRST) state_nxt = FWD;
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  // Output / datapath next values
  always_comb begin
    tgt_strobe_nxt = '0;
    tgt_start_nxt  = '0;
    tgt_data_nxt   = tgt_data_q;
    byte_cnt_nxt   = byte_cnt;
    subcmd_nxt     = subcmd_q;
    int_mask_nxt   = int_mask;
    idle_cnt_nxt   = idle_cnt;
    self_resp      = 8'h00;
    data_out_nxt   = 8'h00;

    // Start bytes never forward: the abort and the id latch happen instead.
    if (body_byte && (state == FWD_FIRST || state == FWD)) begin
      tgt_strobe_nxt = sel_onehot;
      tgt_data_nxt   = bus.data_in;
      if (state == FWD_FIRST) tgt_start_nxt = sel_onehot;
    end

    unique case (byte_idx)
      4'd1: self_resp = SELF_ACK;
      4'd2: if (subcmd_q == SUB_STATUS) self_resp = 8'(int_pend);
      4'd3: if (subcmd_q == SUB_STATUS) self_resp = 8'(int_mask);
      default: self_resp = 8'h00;
    endcase

    if (body_byte && state == SELF) begin
      byte_cnt_nxt = byte_idx;
      if (byte_idx == 4'd1) subcmd_nxt = bus.data_in;
      if (byte_idx == 4'd2 && subcmd_q == SUB_SET_MASK)
        int_mask_nxt = bus.data_in[NUM_TGT-1:0];
    end else if (start_byte || timeout) begin
      byte_cnt_nxt = '0;
    end

    if (bus.data_in_strobe || timeout) idle_cnt_nxt = '0;
    else if (state != IDLE)            idle_cnt_nxt = idle_cnt + CW'(1);

    // data_out follows the state being entered so it lines up with the byte.
    unique case (state_nxt)
      IDLE:           data_out_nxt = 8'h00;
      FWD_FIRST, FWD: data_out_nxt = sel_dout;
      DISCARD:        data_out_nxt = 8'hFF;
      SELF: begin
        if (start_byte)     data_out_nxt = 8'h00;
        else if (body_byte) data_out_nxt = self_resp;
        else                data_out_nxt = data_out_q;
      end
      default:        data_out_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q        <= '0;
      idle_cnt     <= '0;
      byte_cnt     <= '0;
      subcmd_q     <= 8'h00;
      int_mask     <= '1;
      data_out_q   <= 8'h00;
      tgt_strobe_q <= '0;
      tgt_start_q  <= '0;
      tgt_data_q   <= 8'h00;
      int_out_n_q  <= 1'b1;
    end else begin
      sel_q        <= sel_nxt;
      idle_cnt     <= idle_cnt_nxt;
      byte_cnt     <= byte_cnt_nxt;
      subcmd_q     <= subcmd_nxt;
      int_mask     <= int_mask_nxt;
      data_out_q   <= data_out_nxt;
      tgt_strobe_q <= tgt_strobe_nxt;
      tgt_start_q  <= tgt_start_nxt;
      tgt_data_q   <= tgt_data_nxt;
      int_out_n_q  <= ~|int_pend;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.tgt_strobe = tgt_strobe_q;
  assign bus.tgt_start  = tgt_start_q;
  assign bus.tgt_data   = tgt_data_q;
  assign bus.int_out_n  = int_out_n_q;

endmodule

// File: tb/tb_mcu_dispatch.sv
// tb_mcu_dispatch
// Directed bench for mcu_dispatch with a short TIMEOUT. Inputs change on the
// falling edge, outputs are checked on the falling edge after the capturing
// rising edge.
module tb_mcu_dispatch;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses [4] = '{default: 0};
  int hot_viol   = 0;
  int snap_total;
  int snap_t0;

  mcu_dispatch_if bus_if ();

  mcu_dispatch #(.TIMEOUT(TO), .NUM_TGT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (bus_if.tgt_strobe[i]) pulses[i]++;
    if ($countones(bus_if.tgt_strobe) > 1) hot_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge with the strobe removed.
  task automatic send(input logic start, input logic [7:0] b);
    bus_if.data_in_strobe = 1'b1;
    bus_if.data_in_start  = start;
    bus_if.data_in        = b;
    @(negedge clk);
    bus_if.data_in_strobe = 1'b0;
    bus_if.data_in_start  = 1'b0;
    bus_if.data_in        = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int total_pulses();
    return pulses[0] + pulses[1] + pulses[2] + pulses[3];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset                 = 1'b1;
    bus_if.data_in_strobe = 1'b0;
    bus_if.data_in_start  = 1'b0;
    bus_if.data_in        = 8'h00;
    bus_if.tgt_dout       = 32'h773C_4299;
    bus_if.tgt_int        = 4'h0;

    idle(3);
    check("rst_data_out",  32'(bus_if.data_out),   32'h00);
    check("rst_strobe",    32'(bus_if.tgt_strobe), 32'h0);
    check("rst_start",     32'(bus_if.tgt_start),  32'h0);
    check("rst_tgt_data",  32'(bus_if.tgt_data),   32'h00);
    check("rst_int_out_n", 32'(bus_if.int_out_n),  32'h1);
    reset = 1'b0;

    // Forwarded frame to target 1
    send(1'b1, 8'h02);
    check("fwd_id_no_strobe", 32'(bus_if.tgt_strobe), 32'h0);
    send(1'b0, 8'h07);
    check("fwd_cmd_strobe",   32'(bus_if.tgt_strobe), 32'b0010);
    check("fwd_cmd_start",    32'(bus_if.tgt_start),  32'b0010);
    check("fwd_cmd_data",     32'(bus_if.tgt_data),   32'h07);
    check("fwd_data_out",     32'(bus_if.data_out),   32'h42);
    send(1'b0, 8'hAA);
    check("fwd_byte_strobe",  32'(bus_if.tgt_strobe), 32'b0010);
    check("fwd_byte_start",   32'(bus_if.tgt_start),  32'b0000);
    check("fwd_byte_data",    32'(bus_if.tgt_data),   32'hAA);
    idle(1);
    check("fwd_pulse_one_clk", 32'(bus_if.tgt_strobe), 32'h0);
    check("fwd_data_hold",    32'(bus_if.tgt_data),   32'hAA);

    // Unknown id
    snap_total = total_pulses();
    send(1'b1, 8'h09);
    check("disc_data_out", 32'(bus_if.data_out), 32'hFF);
    send(1'b0, 8'h11);
    check("disc_strobe",   32'(bus_if.tgt_strobe), 32'h0);
    check("disc_data_out2", 32'(bus_if.data_out), 32'hFF);
    idle(1);
    check("disc_no_pulses", 32'(total_pulses()), 32'(snap_total));

    // Self: set mask to 0101
    send(1'b1, 8'h00);
    send(1'b0, 8'h01);
    check("self_ack_set", 32'(bus_if.data_out), 32'h5D);
    send(1'b0, 8'h05);
    bus_if.tgt_int = 4'hF;
    idle(1);
    check("int_asserted", 32'(bus_if.int_out_n), 32'h0);
    bus_if.tgt_int = 4'b1010;
    idle(1);
    check("int_masked",   32'(bus_if.int_out_n), 32'h1);
    bus_if.tgt_int = 4'hF;
    idle(1);
    // Self: status readback
    send(1'b1, 8'h00);
    send(1'b0, 8'h00);
    check("self_ack_status", 32'(bus_if.data_out), 32'h5D);
    send(1'b0, 8'h33);
    check("self_int_status", 32'(bus_if.data_out), 32'h05);
    send(1'b0, 8'h44);
    check("self_mask_read",  32'(bus_if.data_out), 32'h05);
    send(1'b0, 8'h55);
    check("self_later_zero", 32'(bus_if.data_out), 32'h00);
    // Unknown subcommand
    send(1'b1, 8'h00);
    send(1'b0, 8'h07);
    check("self_ack_unknown", 32'(bus_if.data_out), 32'h5D);
    send(1'b0, 8'h12);
    check("self_unknown_zero", 32'(bus_if.data_out), 32'h00);

    // Timeout boundary: strobe on the terminal-count cycle keeps the frame
    send(1'b1, 8'h01);
    send(1'b0, 8'h03);
    check("to_cmd_strobe", 32'(bus_if.tgt_strobe), 32'b0001);
    idle(TO);
    check("to_edge_open_dout", 32'(bus_if.data_out), 32'h99);
    send(1'b0, 8'h04);
    check("to_edge_strobe", 32'(bus_if.tgt_strobe), 32'b0001);
    check("to_edge_start",  32'(bus_if.tgt_start),  32'b0000);
    idle(TO + 1);
    check("to_idle_dout", 32'(bus_if.data_out), 32'h00);
    send(1'b0, 8'h05);
    check("to_no_strobe", 32'(bus_if.tgt_strobe), 32'h0);

    // Abort by a new start byte
    send(1'b1, 8'h01);
    send(1'b0, 8'h03);
    check("ab_cmd_strobe", 32'(bus_if.tgt_strobe), 32'b0001);
    send(1'b0, 8'h04);
    check("ab_byte_strobe", 32'(bus_if.tgt_strobe), 32'b0001);
    idle(1);
    snap_t0 = pulses[0];
    send(1'b1, 8'h03);
    check("ab_id_no_strobe", 32'(bus_if.tgt_strobe), 32'h0);
    check("ab_new_dout",     32'(bus_if.data_out),   32'h3C);
    send(1'b0, 8'h66);
    check("ab_new_strobe", 32'(bus_if.tgt_strobe), 32'b0100);
    check("ab_new_start",  32'(bus_if.tgt_start),  32'b0100);
    check("ab_new_data",   32'(bus_if.tgt_data),   32'h66);
    check("ab_old_quiet",  32'(pulses[0]),         32'(snap_t0));

    // Reset mid-frame
    send(1'b1, 8'h02);
    send(1'b0, 8'h10);
    check("mr_cmd_strobe", 32'(bus_if.tgt_strobe), 32'b0010);
    reset = 1'b1;
    idle(2);
    check("mr_data_out",  32'(bus_if.data_out),   32'h00);
    check("mr_strobe",    32'(bus_if.tgt_strobe), 32'h0);
    check("mr_start",     32'(bus_if.tgt_start),  32'h0);
    check("mr_tgt_data",  32'(bus_if.tgt_data),   32'h00);
    check("mr_int_out_n", 32'(bus_if.int_out_n),  32'h1);
    reset = 1'b0;
    snap_total = total_pulses();
    send(1'b0, 8'h20);
    check("mr_byte2_dropped", 32'(bus_if.tgt_strobe), 32'h0);
    bus_if.tgt_int = 4'b0010;
    idle(1);
    check("mr_mask_reset", 32'(bus_if.int_out_n), 32'h0);
    check("mr_no_pulses",  32'(total_pulses()), 32'(snap_total));

    check("one_hot_strobe", 32'(hot_viol), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_dispatch.md
MCU_DISPATCH -- requirements
Module: mcu_dispatch

Interface
Parameters:
REQ-001 The block SHALL have a parameter TIMEOUT, default 50000: the number of idle clk cycles inside an open frame before the frame is aborted.
REQ-002 The block SHALL have a parameter NUM_TGT, default 4: the number of downstream targets, fixed at 4 for this revision.

Ports (name  direction  width  meaning):
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 data_in_strobe  in  1  one-cycle pulse marking a valid byte from the MCU link.
REQ-006 data_in_start  in  1  qualifies data_in_strobe; the byte is the first byte of a frame.
REQ-007 data_in  in  8  byte from the MCU.
REQ-008 data_out  out  8  byte returned to the MCU.
REQ-009 tgt_strobe  out  4  per-target byte strobe.
REQ-010 tgt_start  out  4  per-target frame-start qualifier.
REQ-011 tgt_data  out  8  forwarded byte, shared by all targets.
REQ-012 tgt_dout  in  32  target data_out buses; target i drives bits [8i+7:8i].
REQ-013 tgt_int  in  4  level interrupt request from each target.
REQ-014 int_out_n  out  1  active-low interrupt line to the MCU.

Function
REQ-015 Frame byte 0 (start) is the target id: 0x00 selects the dispatcher itself; 0x01..0x04 select targets 0..3; any other value selects DISCARD.
REQ-016 FSM states: IDLE, FWD_FIRST, FWD, SELF, DISCARD.
REQ-017 FSM transitions on a start strobe from any state: id 0x00 -> SELF; id 0x01..0x04 -> FWD_FIRST; other id -> DISCARD.
REQ-018 FSM transitions on a non-start strobe: FWD_FIRST -> FWD; FWD, SELF and DISCARD hold their state.
REQ-019 The id byte itself SHALL NOT be forwarded to any target.
REQ-020 In FWD_FIRST, a non-start strobe SHALL pulse tgt_strobe[sel] and tgt_start[sel] together, with tgt_data set to the byte; this byte becomes the target's command byte.
REQ-021 In FWD, each strobe SHALL pulse tgt_strobe[sel] alone, with tgt_data set to the byte.
REQ-022 Forwarding latency SHALL be exactly 1 clk after data_in_strobe; at most one tgt_strobe bit is high in any cycle.
REQ-023 A start strobe in any state SHALL abort the current frame; no strobe reaches the old target for that byte, and the new id is latched.
REQ-024 Strobes arriving while in IDLE without data_in_start SHALL be ignored.
REQ-025 data_out is registered every clk: in FWD_FIRST/FWD it is tgt_dout[sel]; in DISCARD it is 0xFF; in IDLE it is 0x00; in SELF it is per REQ-026..REQ-028.
REQ-026 In SELF, byte 1 is the subcommand and data_out returns 0x5D.
REQ-027 SELF subcommand 0x00 (status): byte 2 returns {4'b0, tgt_int & int_mask}; byte 3 returns {4'b0, int_mask}; later bytes return 0x00.
REQ-028 SELF subcommand 0x01 (set mask): byte 2 data_in[3:0] is written to int_mask; later bytes are ignored. Unknown subcommands return 0x00.
REQ-029 A 4-bit byte counter SHALL track bytes within SELF and saturate at 15.
REQ-030 int_out_n SHALL be registered: low when (tgt_int & int_mask) != 0, high otherwise; 1 clk latency.
REQ-031 An idle counter SHALL clear on every data_in_strobe and increment each clk while the state is not IDLE.
REQ-032 When the idle counter reaches TIMEOUT, the FSM SHALL go to IDLE and the counter SHALL clear; a strobe in that same cycle takes priority and prevents the timeout.

Reset
REQ-033 On reset, state SHALL be IDLE, data_out 0x00, tgt_strobe and tgt_start 0, tgt_data 0x00, int_mask 0xF, int_out_n 1, and both counters 0.
REQ-034 A reset asserted mid-frame SHALL drop the frame; no further target strobes are issued until the next start byte.

Verification
REQ-035 Send frame 0x02,0x07,0xAA with tgt_dout[15:8]=0x42 -> tgt_strobe=0010 twice, tgt_start high only with 0x07, tgt_data 0x07 then 0xAA, data_out=0x42.
REQ-036 Send frame 0x09,0x11 -> no tgt_strobe pulses; data_out=0xFF.
REQ-037 Send frame 0x00,0x01,0x05, then tgt_int=1111 -> int_mask=0101, int_out_n=0; then frame 0x00,0x00,x,x -> returns 0x5D, 0x05, 0x05.
REQ-038 Open frame 0x01,0x03, then hold no strobes for TIMEOUT cycles -> state returns to IDLE; a following non-start byte produces no tgt_strobe.
REQ-039 Send frame 0x01,0x03,0x04, then a start byte 0x03 before the next byte -> target 0 receives no further strobes; the next byte pulses tgt_strobe[2] with tgt_start.
REQ-040 Assert reset between byte 1 and byte 2 of a forwarded frame -> outputs match REQ-033 and byte 2 is not forwarded.
